// File: rtl/collision_detector.sv
// Turns per-pixel drawing-request overlaps into per-frame game events and hands them
// to the game controller once per frame over a valid/ack handshake.
module collision_detector #(
    parameter int N_PR  = 3,
    parameter int N_AR  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             smileyDrawingRequest,
    input  logic [N_PR-1:0]  p_rockets_DR,
    input  logic [N_AR-1:0]  a_rockets_DR,
    input  logic             AliensDrawingRequest,
    input  logic             hit_ack,
    output logic             hit_valid,
    output logic             player_hit,
    output logic [N_PR-1:0]  p_rocket_hit,
    output logic [N_AR-1:0]  a_rocket_kill,
    output logic [N_PR-1:0]  p_rocket_clash,
    output logic [CNT_W-1:0] alien_hit_pixels,
    output logic             overrun
);

    // state | meaning
    // IDLE  | no unconsumed report; report outputs are don't-care
    // PEND  | report registers hold a report the controller has not acked
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x,
                                                 input logic [CNT_W-1:0] y);
        logic [CNT_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    logic            sof_q, smiley_q, aliens_q;
    logic [N_PR-1:0] p_q;
    logic [N_AR-1:0] a_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sof_q    <= 1'b0;
            smiley_q <= 1'b0;
            aliens_q <= 1'b0;
            p_q      <= '0;
            a_q      <= '0;
        end else begin
            sof_q    <= startOfFrame;
            smiley_q <= smileyDrawingRequest;
            aliens_q <= AliensDrawingRequest;
            p_q      <= p_rockets_DR;
            a_q      <= a_rockets_DR;
        end
    end

    logic            ph, ap;
    logic [N_PR-1:0] prh, pc;
    logic [N_AR-1:0] ak;

    assign ph  = smiley_q & (|a_q);
    assign prh = p_q & {N_PR{aliens_q}};
    assign ak  = a_q & {N_AR{smiley_q | (|p_q)}};
    assign pc  = p_q & {N_PR{|a_q}};
    assign ap  = |prh;

    logic             acc_ph;
    logic [N_PR-1:0]  acc_prh, acc_pc;
    logic [N_AR-1:0]  acc_ak;
    logic [CNT_W-1:0] cnt;

    // The boundary pixel is folded into the snapshot, so the accumulators restart empty.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_ph  <= 1'b0;
            acc_prh <= '0;
            acc_pc  <= '0;
            acc_ak  <= '0;
            cnt     <= '0;
        end else if (sof_q) begin
            acc_ph  <= 1'b0;
            acc_prh <= '0;
            acc_pc  <= '0;
            acc_ak  <= '0;
            cnt     <= '0;
        end else begin
            acc_ph  <= acc_ph | ph;
            acc_prh <= acc_prh | prh;
            acc_pc  <= acc_pc | pc;
            acc_ak  <= acc_ak | ak;
            cnt     <= sat_add(cnt, CNT_W'(ap));
        end
    end

    logic             snap_ph, any_new;
    logic [N_PR-1:0]  snap_prh, snap_pc;
    logic [N_AR-1:0]  snap_ak;
    logic [CNT_W-1:0] cnt_snap;

    assign snap_ph  = acc_ph | ph;
    assign snap_prh = acc_prh | prh;
    assign snap_pc  = acc_pc | pc;
    assign snap_ak  = acc_ak | ak;
    assign cnt_snap = sat_add(cnt, CNT_W'(ap));
    assign any_new  = snap_ph | (|snap_prh) | (|snap_pc) | (|snap_ak);

    state_t           state, state_nxt;
    logic             ph_nxt, ovr_nxt;
    logic [N_PR-1:0]  prh_nxt, pc_nxt;
    logic [N_AR-1:0]  ak_nxt;
    logic [CNT_W-1:0] pix_nxt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            player_hit       <= 1'b0;
            p_rocket_hit     <= '0;
            a_rocket_kill    <= '0;
            p_rocket_clash   <= '0;
            alien_hit_pixels <= '0;
            overrun          <= 1'b0;
        end else begin
            state            <= state_nxt;
            player_hit       <= ph_nxt;
            p_rocket_hit     <= prh_nxt;
            a_rocket_kill    <= ak_nxt;
            p_rocket_clash   <= pc_nxt;
            alien_hit_pixels <= pix_nxt;
            overrun          <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = player_hit;
        prh_nxt   = p_rocket_hit;
        ak_nxt    = a_rocket_kill;
        pc_nxt    = p_rocket_clash;
        pix_nxt   = alien_hit_pixels;
        ovr_nxt   = overrun;
        case (state)
            IDLE: begin
                if (sof_q && any_new) begin
                    ph_nxt    = snap_ph;
                    prh_nxt   = snap_prh;
                    ak_nxt    = snap_ak;
                    pc_nxt    = snap_pc;
                    pix_nxt   = cnt_snap;
                    ovr_nxt   = 1'b0;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (sof_q && hit_ack) begin
                    // Ack and boundary together: old report is gone, start fresh.
                    ph_nxt    = snap_ph;
                    prh_nxt   = snap_prh;
                    ak_nxt    = snap_ak;
                    pc_nxt    = snap_pc;
                    pix_nxt   = cnt_snap;
                    ovr_nxt   = 1'b0;
                    state_nxt = any_new ? PEND : IDLE;
                end else if (sof_q) begin
                    if (any_new) begin
                        ph_nxt  = player_hit | snap_ph;
                        prh_nxt = p_rocket_hit | snap_prh;
                        ak_nxt  = a_rocket_kill | snap_ak;
                        pc_nxt  = p_rocket_clash | snap_pc;
                        pix_nxt = sat_add(alien_hit_pixels, cnt_snap);
                        ovr_nxt = 1'b1;
                    end
                end else if (hit_ack) begin
                    ovr_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hit_valid = (state == PEND);

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: fixed vector table, hand-written corner
// sequences and a randomized run checked against a per-frame event model.
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame, smileyDrawingRequest, AliensDrawingRequest, hit_ack;
    logic [2:0] p_rockets_DR, a_rockets_DR;
    logic       hit_valid, player_hit, overrun;
    logic [2:0] p_rocket_hit, a_rocket_kill, p_rocket_clash;
    logic [7:0] alien_hit_pixels;

    collision_detector #(.N_PR(3), .N_AR(3), .CNT_W(8)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .smileyDrawingRequest(smileyDrawingRequest), .p_rockets_DR(p_rockets_DR),
        .a_rockets_DR(a_rockets_DR), .AliensDrawingRequest(AliensDrawingRequest),
        .hit_ack(hit_ack), .hit_valid(hit_valid), .player_hit(player_hit),
        .p_rocket_hit(p_rocket_hit), .a_rocket_kill(a_rocket_kill),
        .p_rocket_clash(p_rocket_clash), .alien_hit_pixels(alien_hit_pixels),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: report state, open-frame event sets, and the pixel awaiting evaluation.
    logic       m_valid, m_ph, m_ovr;
    logic [2:0] m_prh, m_ak, m_pc;
    int         m_pix;
    logic       f_ph;
    logic [2:0] f_prh, f_ak, f_pc;
    int         f_cnt;
    logic       pv_sof, pv_sm, pv_al;
    logic [2:0] pv_p, pv_a;

    typedef struct {
        logic       sof, sm;
        logic [2:0] p, a;
        logic       al, ack;
        logic       ev, eph;
        logic [2:0] eprh, eak, epc;
        logic [7:0] epix;
        logic       eovr, chk_rep;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [19:0] dut_vec();
        return {hit_valid, player_hit, p_rocket_hit, a_rocket_kill, p_rocket_clash,
                alien_hit_pixels, overrun};
    endfunction

    function automatic logic [19:0] model_vec();
        return {m_valid, m_ph, m_prh, m_ak, m_pc, m_pix[7:0], m_ovr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ph = 0; m_ovr = 0; m_prh = 0; m_ak = 0; m_pc = 0; m_pix = 0;
        f_ph = 0; f_prh = 0; f_ak = 0; f_pc = 0; f_cnt = 0;
        pv_sof = 0; pv_sm = 0; pv_al = 0; pv_p = 0; pv_a = 0;
    endtask

    task automatic model_edge(input logic ack);
        logic       ph, s_ph, any;
        logic [2:0] prh, ak, pc, s_prh, s_ak, s_pc;
        int         s_cnt;
        ph  = pv_sm && (pv_a != 0);
        prh = pv_al ? pv_p : 3'b000;
        ak  = (pv_sm || pv_p != 0) ? pv_a : 3'b000;
        pc  = (pv_a != 0) ? pv_p : 3'b000;
        if (!pv_sof) begin
            f_ph |= ph; f_prh |= prh; f_ak |= ak; f_pc |= pc;
            f_cnt += (prh != 0) ? 1 : 0;
            if (m_valid && ack) begin
                m_valid = 0;
                m_ovr   = 0;
            end
        end else begin
            s_ph  = f_ph | ph; s_prh = f_prh | prh; s_ak = f_ak | ak; s_pc = f_pc | pc;
            s_cnt = f_cnt + ((prh != 0) ? 1 : 0);
            if (s_cnt > 255) s_cnt = 255;
            any = s_ph || (s_prh != 0) || (s_ak != 0) || (s_pc != 0);
            if (m_valid && !ack) begin
                if (any) begin
                    m_ph |= s_ph; m_prh |= s_prh; m_ak |= s_ak; m_pc |= s_pc;
                    m_pix = (m_pix + s_cnt > 255) ? 255 : m_pix + s_cnt;
                    m_ovr = 1;
                end
            end else if (m_valid || any) begin
                m_ph = s_ph; m_prh = s_prh; m_ak = s_ak; m_pc = s_pc;
                m_pix = s_cnt; m_ovr = 0; m_valid = any;
            end
            f_ph = 0; f_prh = 0; f_ak = 0; f_pc = 0; f_cnt = 0;
        end
    endtask

    // One pixel clock: drive at the falling edge, advance the model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input logic sof, input logic sm, input logic [2:0] p,
                         input logic [2:0] a, input logic al, input logic ack);
        startOfFrame = sof; smileyDrawingRequest = sm; p_rockets_DR = p;
        a_rockets_DR = a; AliensDrawingRequest = al; hit_ack = ack;
        @(posedge clk);
        model_edge(ack);
        pv_sof = sof; pv_sm = sm; pv_p = p; pv_a = a; pv_al = al;
        @(negedge clk);
        chk("outputs_vs_model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 3'b000, 3'b000, 0, 0);
    endtask

    task automatic do_reset();
        startOfFrame = 0; smileyDrawingRequest = 0; p_rockets_DR = 0;
        a_rockets_DR = 0; AliensDrawingRequest = 0; hit_ack = 0;
        resetN = 0;
        #1;
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        resetN = 1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b100, 3'b000, 8'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 8'd1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 8'd1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 3'b001, 8'd0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 8'd0, 1'b0, 1'b0};

        model_reset();
        @(negedge clk);
        do_reset();

        // Three empty frames.
        for (int f = 0; f < 3; f++) begin
            cycle(1, 0, 3'b000, 3'b000, 0, 0);
            idle(7);
        end
        chk("empty_frames", 32'(dut_vec()), 32'd0);

        // Rocket 1 over aliens for 5 pixels, then a delayed ack.
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 3'b010, 3'b000, 1, 0);
        idle(1);
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        chk("valid_before_boundary_eval", 32'(hit_valid), 32'd0);
        idle(1);
        chk("valid_after_boundary", 32'(hit_valid), 32'd1);
        chk("p_rocket_hit_single", 32'(p_rocket_hit), 32'b010);
        chk("alien_pixels_5", 32'(alien_hit_pixels), 32'd5);
        chk("player_hit_clear", 32'(player_hit), 32'd0);
        idle(2);
        chk("valid_held", 32'(hit_valid), 32'd1);
        cycle(0, 0, 3'b000, 3'b000, 0, 1);
        chk("valid_dropped_on_ack", 32'(hit_valid), 32'd0);

        // Vector table: player hit, then ack coinciding with a clash boundary.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].sof, tbl[i].sm, tbl[i].p, tbl[i].a, tbl[i].al, tbl[i].ack);
            chk($sformatf("tbl%0d_valid", i), 32'(hit_valid), 32'(tbl[i].ev));
            if (tbl[i].chk_rep)
                chk($sformatf("tbl%0d_report", i),
                    32'({player_hit, p_rocket_hit, a_rocket_kill, p_rocket_clash, alien_hit_pixels, overrun}),
                    32'({tbl[i].eph, tbl[i].eprh, tbl[i].eak, tbl[i].epc, tbl[i].epix, tbl[i].eovr}));
        end

        // Overrun: two frames merged without an ack.
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 3'b001, 3'b000, 1, 0);
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        for (int k = 0; k < 2; k++) cycle(0, 0, 3'b100, 3'b000, 1, 0);
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        idle(1);
        chk("overrun_prh", 32'(p_rocket_hit), 32'b101);
        chk("overrun_pixels", 32'(alien_hit_pixels), 32'd5);
        chk("overrun_flag", 32'(overrun), 32'd1);
        cycle(0, 0, 3'b000, 3'b000, 0, 1);
        chk("overrun_ack", 32'({hit_valid, overrun}), 32'd0);

        // Counter saturation.
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        for (int k = 0; k < 300; k++) cycle(0, 0, 3'b001, 3'b000, 1, 0);
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        idle(1);
        chk("saturated_pixels", 32'(alien_hit_pixels), 32'd255);
        cycle(0, 0, 3'b000, 3'b000, 0, 1);

        // Reset mid-frame with a report pending; only post-release pixels count afterwards.
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        cycle(0, 0, 3'b100, 3'b000, 1, 0);
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        cycle(0, 0, 3'b100, 3'b000, 1, 0);
        chk("pending_before_reset", 32'(hit_valid), 32'd1);
        do_reset();
        for (int k = 0; k < 2; k++) cycle(0, 0, 3'b001, 3'b000, 1, 0);
        cycle(1, 0, 3'b000, 3'b000, 0, 0);
        idle(1);
        chk("post_reset_prh", 32'(p_rocket_hit), 32'b001);
        chk("post_reset_pixels", 32'(alien_hit_pixels), 32'd2);
        cycle(0, 0, 3'b000, 3'b000, 0, 1);

        // Randomized frames against the model.
        for (int f = 0; f < 80; f++) begin
            int  len;
            bit  quiet;
            len   = $urandom_range(4, 40);
            quiet = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < len; k++) begin
                logic       sm, al;
                logic [2:0] p, a;
                sm = !quiet && ($urandom_range(0, 5) == 0);
                p  = quiet ? 3'b000 : 3'($urandom_range(0, 7) & $urandom_range(0, 7));
                a  = quiet ? 3'b000 : 3'($urandom_range(0, 7) & $urandom_range(0, 7));
                al = !quiet && ($urandom_range(0, 2) == 0);
                cycle(k == 0, sm, p, a, al, $urandom_range(0, 7) == 0);
            end
            if (f == 40) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
